// File: rtl/dm_access_if.sv
// Request/response and data-memory port bundle of the data-memory access unit.
// The unit connects through the slave modport; the requester/memory side uses master.
interface dm_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic [4:0]  req_rd;

  logic [31:0] m_data_addr;
  logic [31:0] m_data_rdata;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_pc;
  logic        rsp_exc;

  // Request: transfer on a rising edge with req_valid && req_ready; the requester holds
  // req_valid and its fields until then. Response: rsp_valid is a one-cycle pulse with no
  // back-pressure; rsp_rdata/rsp_rd/rsp_pc/rsp_exc hold their values between pulses.
  modport slave (
    input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc, req_rd,
    input  m_data_rdata,
    output req_ready,
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    output rsp_valid, rsp_rdata, rsp_rd, rsp_pc, rsp_exc
  );

  modport master (
    output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc, req_rd,
    output m_data_rdata,
    input  req_ready,
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    input  rsp_valid, rsp_rdata, rsp_rd, rsp_pc, rsp_exc
  );
endinterface

// File: rtl/dm_access_unit.sv
// Load/store initiator for the data-memory port: lane-aligned stores, fixed-latency loads.
// Optional feature macro MISALIGN_CHK_EN: misaligned half/word accesses return rsp_exc=1.
module dm_access_unit #(
  parameter int unsigned RD_LAT = 0
) (
  input  logic           clk,
  input  logic           reset,
  dm_access_if.slave     bus,
  output logic [1:0]     dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        we_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [1:0]  lane_q;
  logic [4:0]  rd_q;
  logic [31:0] pc_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_pc_q;
  logic [31:0] rsp_rdata_q;
  logic [4:0]  rsp_rd_q;
  logic [31:0] rsp_pc_q;

  logic        accept;
  logic        misalign;
  logic        lat_done;
  logic        load_done;
  logic [3:0]  be_calc;
  logic [31:0] wdata_rep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;

  assign accept    = bus.req_valid && (state_q == S_IDLE);
  assign lat_done  = (cnt_q == 4'(RD_LAT));
  assign load_done = (state_q == S_ACCESS) && !we_q && lat_done;

`ifdef MISALIGN_CHK_EN
  logic rsp_exc_q;
  assign misalign = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                    (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
  assign bus.rsp_exc = rsp_exc_q;
`else
  assign misalign    = 1'b0;
  assign bus.rsp_exc = 1'b0;
`endif

  // Lane decode of the incoming request; half and word ignore the low address bits.
  always_comb begin
    be_calc   = 4'b1111;
    wdata_rep = bus.req_wdata;
    case (bus.req_size)
      2'd0: begin
        be_calc   = 4'b0001 << bus.req_addr[1:0];
        wdata_rep = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        be_calc   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be_calc   = 4'b1111;
        wdata_rep = bus.req_wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = bus.m_data_rdata[7:0];
    case (lane_q)
      2'd0:    ld_byte = bus.m_data_rdata[7:0];
      2'd1:    ld_byte = bus.m_data_rdata[15:8];
      2'd2:    ld_byte = bus.m_data_rdata[23:16];
      default: ld_byte = bus.m_data_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? bus.m_data_rdata[31:16] : bus.m_data_rdata[15:0];
    case (size_q)
      2'd0:    load_ext = {{24{sext_q & ld_byte[7]}}, ld_byte};
      2'd1:    load_ext = {{16{sext_q & ld_half[15]}}, ld_half};
      default: load_ext = bus.m_data_rdata;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if (accept) state_d = misalign ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else if (lat_done) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. byteen comes straight from state so reset kills a store at once.
  always_comb begin
    bus.req_ready     = (state_q == S_IDLE);
    bus.rsp_valid     = (state_q == S_RESP);
    bus.m_data_byteen = ((state_q == S_ACCESS) && we_q) ? be_q : 4'b0000;
    dbg_state_o       = state_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      sext_q      <= 1'b0;
      lane_q      <= 2'd0;
      rd_q        <= 5'd0;
      pc_q        <= 32'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      m_addr_q    <= 32'd0;
      m_pc_q      <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_rd_q    <= 5'd0;
      rsp_pc_q    <= 32'd0;
`ifdef MISALIGN_CHK_EN
      rsp_exc_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        we_q   <= bus.req_we;
        size_q <= bus.req_size;
        sext_q <= bus.req_sext;
        lane_q <= bus.req_addr[1:0];
        rd_q   <= bus.req_rd;
        pc_q   <= bus.req_pc;
        be_q   <= be_calc;
        // The port address only moves for accesses that actually reach memory.
        if (!misalign) begin
          m_addr_q <= bus.req_addr;
          m_pc_q   <= bus.req_pc;
          wdata_q  <= wdata_rep;
        end
`ifdef MISALIGN_CHK_EN
        else begin
          rsp_rdata_q <= 32'd0;
          rsp_rd_q    <= bus.req_rd;
          rsp_pc_q    <= bus.req_pc;
          rsp_exc_q   <= 1'b1;
        end
`endif
      end
      if (load_done) begin
        rsp_rdata_q <= load_ext;
        rsp_rd_q    <= rd_q;
        rsp_pc_q    <= pc_q;
`ifdef MISALIGN_CHK_EN
        rsp_exc_q   <= 1'b0;
`endif
      end
    end
  end

  assign bus.m_data_addr  = m_addr_q;
  assign bus.m_inst_addr  = m_pc_q;
  assign bus.m_data_wdata = wdata_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_rd       = rsp_rd_q;
  assign bus.rsp_pc       = rsp_pc_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: RD_LAT=0 and RD_LAT=3 instances against a byte-addressed model.
module tb_dm_access_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  dm_access_if if0();
  dm_access_if if3();
  logic [1:0] dbg0, dbg3;

  dm_access_unit #(.RD_LAT(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave), .dbg_state_o(dbg0));
  dm_access_unit #(.RD_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3.slave), .dbg_state_o(dbg3));

  // Per-instance stimulus and observation, index 0 -> RD_LAT=0, index 1 -> RD_LAT=3
  logic        v[2], we[2], sx[2];
  logic [1:0]  sz[2];
  logic [31:0] ra[2], rw[2], rp[2];
  logic [4:0]  rr[2];
  logic        rdy[2], rv[2], rexc[2];
  logic [3:0]  be[2];
  logic [31:0] ad[2], wd[2], ia[2], rdat[2], rpc[2];
  logic [4:0]  rrd[2];

  logic [7:0]  mb[2][64];
  logic [31:0] mem[2][16];

  assign if0.req_valid = v[0];  assign if3.req_valid = v[1];
  assign if0.req_we    = we[0]; assign if3.req_we    = we[1];
  assign if0.req_size  = sz[0]; assign if3.req_size  = sz[1];
  assign if0.req_sext  = sx[0]; assign if3.req_sext  = sx[1];
  assign if0.req_addr  = ra[0]; assign if3.req_addr  = ra[1];
  assign if0.req_wdata = rw[0]; assign if3.req_wdata = rw[1];
  assign if0.req_pc    = rp[0]; assign if3.req_pc    = rp[1];
  assign if0.req_rd    = rr[0]; assign if3.req_rd    = rr[1];
  assign rdy[0] = if0.req_ready;     assign rdy[1] = if3.req_ready;
  assign be[0]  = if0.m_data_byteen; assign be[1]  = if3.m_data_byteen;
  assign ad[0]  = if0.m_data_addr;   assign ad[1]  = if3.m_data_addr;
  assign wd[0]  = if0.m_data_wdata;  assign wd[1]  = if3.m_data_wdata;
  assign ia[0]  = if0.m_inst_addr;   assign ia[1]  = if3.m_inst_addr;
  assign rv[0]  = if0.rsp_valid;     assign rv[1]  = if3.rsp_valid;
  assign rdat[0]= if0.rsp_rdata;     assign rdat[1]= if3.rsp_rdata;
  assign rrd[0] = if0.rsp_rd;        assign rrd[1] = if3.rsp_rd;
  assign rpc[0] = if0.rsp_pc;        assign rpc[1] = if3.rsp_pc;
  assign rexc[0]= if0.rsp_exc;       assign rexc[1]= if3.rsp_exc;
  assign if0.m_data_rdata = mem[0][ad[0][5:2]];
  assign if3.m_data_rdata = mem[1][ad[1][5:2]];

  // Memory: loaded from the model while in reset, byteen-gated writes otherwise
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (!reset) begin
        for (int w = 0; w < 16; w++)
          mem[s][w] <= {mb[s][4*w+3], mb[s][4*w+2], mb[s][4*w+1], mb[s][4*w]};
      end else begin
        for (int i = 0; i < 4; i++)
          if (be[s][i]) mem[s][ad[s][5:2]][8*i +: 8] <= wd[s][8*i +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int s);
    return (s == 0) ? 0 : 3;
  endfunction

  function automatic int nbytes(input int size);
    return (size == 0) ? 1 : (size == 1) ? 2 : 4;
  endfunction

  function automatic int base_of(input int addr, input int size);
    return addr - (addr % nbytes(size));
  endfunction

  function automatic bit is_mis(input int addr, input int size);
`ifdef MISALIGN_CHK_EN
    return (addr % nbytes(size)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] exp_be(input int addr, input int size);
    logic [3:0] m;
    int b, w;
    m = 4'b0;
    b = base_of(addr, size);
    w = addr - (addr % 4);
    for (int i = 0; i < 4; i++)
      if ((w + i >= b) && (w + i < b + nbytes(size))) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [31:0] w, input int size);
    if (size == 0) return (w & 32'hFF) * 32'h01010101;
    if (size == 1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input int s, input int addr, input int size, input bit sext);
    logic [31:0] val;
    int b;
    val = 32'd0;
    b = base_of(addr, size);
    for (int i = 0; i < nbytes(size); i++) val = val | (32'(mb[s][b+i]) << (8*i));
    if (sext && size == 0 && val[7])  val = val | 32'hFFFFFF00;
    if (sext && size == 1 && val[15]) val = val | 32'hFFFF0000;
    return val;
  endfunction

  function automatic logic [31:0] model_word(input int s, input int addr);
    int w;
    w = addr - (addr % 4);
    return {mb[s][w+3], mb[s][w+2], mb[s][w+1], mb[s][w]};
  endfunction

  task automatic set_req(input int s, input bit w, input int size, input bit sext,
                         input int addr, input logic [31:0] wdata, input logic [31:0] pc,
                         input logic [4:0] rd);
    we[s] = w; sz[s] = 2'(size); sx[s] = sext; ra[s] = 32'(addr);
    rw[s] = wdata; rp[s] = pc; rr[s] = rd; v[s] = 1'b1;
  endtask

  // One complete transaction, entered and left just after a falling edge with the unit idle
  task automatic run_op(input int s, input bit w, input int size, input bit sext, input int addr,
                        input logic [31:0] wdata, input logic [31:0] pc, input logic [4:0] rd,
                        output logic [31:0] rdata_o);
    logic [31:0] e;
    bit mis;
    mis = is_mis(addr, size);
    rdata_o = 32'd0;
    chk("ready_idle", 32'(rdy[s]), 32'd1);
    if (!w && !mis) exp_q.push_back(model_load(s, addr, size, sext));
    set_req(s, w, size, sext, addr, wdata, pc, rd);
    @(posedge clk); #1 v[s] = 1'b0;
    if (mis) begin
      @(negedge clk);
      chk("mis_byteen", 32'(be[s]), 32'd0);
      chk("mis_rsp_valid", 32'(rv[s]), 32'd1);
      chk("mis_rsp_exc", 32'(rexc[s]), 32'd1);
      chk("mis_rsp_rdata", rdat[s], 32'd0);
      chk("mis_rsp_rd", 32'(rrd[s]), 32'(rd));
      chk("mis_rsp_pc", rpc[s], pc);
      @(negedge clk);
      chk("mis_rsp_end", 32'(rv[s]), 32'd0);
      chk("mis_ready", 32'(rdy[s]), 32'd1);
    end else if (w) begin
      @(negedge clk);
      chk("st_byteen", 32'(be[s]), 32'(exp_be(addr, size)));
      chk("st_addr", ad[s], 32'(addr));
      chk("st_wdata", wd[s], exp_wd(wdata, size));
      chk("st_inst_addr", ia[s], pc);
      chk("st_no_rsp", 32'(rv[s]), 32'd0);
      chk("st_busy", 32'(rdy[s]), 32'd0);
      for (int i = 0; i < nbytes(size); i++)
        mb[s][base_of(addr, size) + i] = 8'(wdata >> (8*i));
      @(negedge clk);
      chk("st_byteen_off", 32'(be[s]), 32'd0);
      chk("st_ready", 32'(rdy[s]), 32'd1);
      chk("st_addr_hold", ad[s], 32'(addr));
      chk("st_mem_word", mem[s][addr/4], model_word(s, addr));
    end else begin
      for (int k = 0; k <= lat_of(s); k++) begin
        @(negedge clk);
        chk("ld_addr", ad[s], 32'(addr));
        chk("ld_inst_addr", ia[s], pc);
        chk("ld_no_byteen", 32'(be[s]), 32'd0);
        chk("ld_wait_no_rsp", 32'(rv[s]), 32'd0);
        chk("ld_busy", 32'(rdy[s]), 32'd0);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      chk("ld_rsp_valid", 32'(rv[s]), 32'd1);
      chk("ld_rsp_rdata", rdat[s], e);
      chk("ld_rsp_rd", 32'(rrd[s]), 32'(rd));
      chk("ld_rsp_pc", rpc[s], pc);
      chk("ld_rsp_exc", 32'(rexc[s]), 32'd0);
      chk("ld_rsp_busy", 32'(rdy[s]), 32'd0);
      rdata_o = rdat[s];
      @(negedge clk);
      chk("ld_rsp_pulse", 32'(rv[s]), 32'd0);
      chk("ld_ready", 32'(rdy[s]), 32'd1);
      chk("ld_rsp_hold", rdat[s], e);
    end
  endtask

  initial begin
    logic [31:0] r, d;
    for (int s = 0; s < 2; s++) begin
      v[s] = 0; we[s] = 0; sz[s] = 0; sx[s] = 0; ra[s] = 0; rw[s] = 0; rp[s] = 0; rr[s] = 0;
      for (int i = 0; i < 64; i++) mb[s][i] = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 32'(rdy[s]), 32'd1);
      chk("rst_byteen", 32'(be[s]), 32'd0);
      chk("rst_rsp_valid", 32'(rv[s]), 32'd0);
      chk("rst_addr", ad[s], 32'd0);
      chk("rst_rsp_rdata", rdat[s], 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);

    // sb lane 1, then the 0x8000FF7F word with signed byte and unsigned half loads
    run_op(0, 1, 0, 0, 5, 32'h000000AB, 32'h100, 5'd1, r);
    chk("sb_lane_word", mem[0][1][15:8], 32'hAB);
    run_op(0, 1, 2, 0, 4, 32'h8000FF7F, 32'h104, 5'd2, r);
    run_op(0, 0, 0, 1, 7, 32'd0, 32'h108, 5'd3, r);
    chk("lb_sext_const", r, 32'hFFFFFF80);
    run_op(0, 0, 1, 0, 4, 32'd0, 32'h10C, 5'd4, r);
    chk("lhu_const", r, 32'h0000FF7F);

    // RD_LAT=3 word load
    run_op(1, 1, 2, 0, 16, 32'hCAFE1234, 32'h200, 5'd5, r);
    run_op(1, 0, 2, 0, 16, 32'd0, 32'h204, 5'd6, r);
    chk("lw_lat3_const", r, 32'hCAFE1234);

    // sw then lw with req_valid held: the load waits for IDLE and sees no byteen
    d = $urandom;
    set_req(0, 1, 2, 0, 32, d, 32'h300, 5'd7);
    @(posedge clk); #1 set_req(0, 0, 2, 0, 32, 32'd0, 32'h304, 5'd8);
    @(negedge clk);
    chk("b2b_st_byteen", 32'(be[0]), 32'hF);
    chk("b2b_busy", 32'(rdy[0]), 32'd0);
    for (int i = 0; i < 4; i++) mb[0][32+i] = 8'(d >> (8*i));
    @(negedge clk);
    chk("b2b_idle_ready", 32'(rdy[0]), 32'd1);
    chk("b2b_idle_byteen", 32'(be[0]), 32'd0);
    @(posedge clk); #1 v[0] = 1'b0;
    @(negedge clk);
    chk("b2b_ld_no_byteen", 32'(be[0]), 32'd0);
    chk("b2b_ld_addr", ad[0], 32'd32);
    chk("b2b_ld_wait", 32'(rv[0]), 32'd0);
    @(negedge clk);
    chk("b2b_ld_rsp", 32'(rv[0]), 32'd1);
    chk("b2b_ld_rdata", rdat[0], d);
    chk("b2b_ld_pc", rpc[0], 32'h304);
    @(negedge clk);

    // Reset in the ACCESS cycle of a store
    set_req(0, 1, 1, 0, 34, $urandom, 32'h400, 5'd9);
    @(posedge clk); #1 v[0] = 1'b0;
    @(negedge clk);
    chk("rst_sh_byteen", 32'(be[0]), 32'hC);
    #1 reset = 1'b0;
    #1 chk("rst_async_byteen", 32'(be[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(rdy[0]), 32'd1);
      chk("post_rst_no_rsp", 32'(rv[0]), 32'd0);
    end
    chk("post_rst_mem", mem[0][8], model_word(0, 32));

    // Misaligned word store (exception with the check, aligned-down write without)
    run_op(0, 1, 2, 0, 2, $urandom, 32'h500, 5'd10, r);
    run_op(0, 0, 2, 0, 0, 32'd0, 32'h504, 5'd11, r);

    // Random mix on both latencies
    for (int i = 0; i < 60; i++) begin
      int s;
      s = i % 2;
      run_op(s, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 63), $urandom, $urandom, 5'($urandom_range(0, 31)), r);
    end

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
